mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access controller for the MEM stage of the five-stage pipeline. It consumes the memory control signals, address and store data held in the EX/MEM pipeline register. It runs a request/ready handshake to an external data memory that may have variable latency, and returns load data to the MEM/WB register. While an access is outstanding it raises a stall that freezes the upstream pipeline registers and bubbles MEM/WB.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent waiting for `mem_ready` before the access is aborted. Legal range is 1–255.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `MemRead`  in  1  load request, from EX/MEM `MemRead_OUT`.
- `MemWrite`  in  1  store request, from EX/MEM `MemWrite_OUT`.
- `ALUResult`  in  32  byte address, from EX/MEM `ALUResult_OUT`.
- `WriteData`  in  32  store data, from EX/MEM `WriteData_OUT`.
- `ReadData_OUT`  out  32  load data, to MEM/WB `readData`.
- `Stall`  out  1  high freezes PC, IF/ID, ID/EX and EX/MEM. Top level gates MEM/WB `RegWrite` with `!Stall`.
- `MemErr`  out  1  one-cycle pulse on a misaligned, conflicting or timed-out access.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable; meaningful only while `mem_req` is high.
- `mem_addr`  out  32  word-aligned bus address.
- `mem_wdata`  out  32  bus store data.
- `mem_ready`  in  1  memory completion strobe; sampled only while `mem_req` is high.
- `mem_rdata`  in  32  memory load data; valid when `mem_ready` is high.

## Operation
The controller has three states: IDLE, REQ and DONE.

IDLE
- An access is present when `MemRead | MemWrite` is high.
- `Stall = 1` combinationally when an access is present.
- Aligned (`ALUResult[1:0]==0`) with exactly one of `MemRead`/`MemWrite` high:
  - latch `mem_addr <= ALUResult`, `mem_wdata <= WriteData`, `mem_we <= MemWrite`;
  - clear the wait counter;
  - go to REQ.
- Misaligned, or `MemRead & MemWrite` both high:
  - go to DONE with `MemErr` pulsed for the DONE cycle;
  - no bus transaction is started;
  - `ReadData_OUT` is unchanged.
- No access: remain in IDLE with `Stall = 0`.

REQ
- `mem_req = 1`, `Stall = 1`.
- `mem_ready = 1`:
  - if the access is a load, `ReadData_OUT <= mem_rdata`;
  - go to DONE.
- Otherwise the 8-bit counter increments.
- When the counter reaches `TIMEOUT - 1` with `mem_ready` low:
  - abort; go to DONE with `MemErr`;
  - `ReadData_OUT <= 0` if the access is a load.

DONE
- `Stall = 0` and `mem_req = 0`.
- EX/MEM and MEM/WB advance at the end of this cycle.
- Unconditionally return to IDLE, so the held instruction is not re-issued.

General rules
- Stores never modify `ReadData_OUT`.
- `ReadData_OUT` holds its value until the next completed load.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole of REQ.
- `mem_ready` is ignored outside REQ.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE.

## Timing
- Reset values (async, immediate):
  - state IDLE, counter 0;
  - `ReadData_OUT`, `mem_addr`, `mem_wdata` = 0;
  - `mem_we`, `mem_req`, `MemErr` = 0.
  - `Stall` reflects IDLE logic only.
- Reset mid-REQ: `mem_req` drops asynchronously. The memory must tolerate an abandoned request.
- Minimum load/store latency is 2 stall cycles:
  - cycle 0: IDLE, access detected;
  - cycle 1: REQ with `mem_ready = 1`;
  - cycle 2: DONE, data valid, `Stall` low.
- A memory wait of N cycles before `mem_ready` gives 2+N stall cycles.
- Error path (misalignment or conflict): 1 stall cycle, then DONE.
- Timeout path: `TIMEOUT` cycles in REQ, followed by DONE.
- `MemErr` is high only in a DONE cycle, for exactly one cycle.
- Non-memory instruction: zero stall cycles.

## Test plan
- **Load, immediate ready:** `MemRead=1`, `ALUResult=0x100`, `mem_ready` high in first REQ cycle, `mem_rdata=0xDEADBEEF` -> `Stall` high 2 cycles; `mem_addr=0x100`, `mem_we=0`; `ReadData_OUT=0xDEADBEEF` in DONE; `MemErr=0`.
- **Store, 3-cycle wait:** `MemWrite=1`, `ALUResult=0x24`, `WriteData=0x12345678`, `mem_ready` on 4th REQ cycle -> `Stall` high 5 cycles; `mem_we=1`, `mem_wdata=0x12345678` held throughout; `ReadData_OUT` unchanged.
- **Misaligned load:** `ALUResult=0x102` -> `mem_req` never asserted; `Stall` high 1 cycle; `MemErr` pulses 1 cycle; `ReadData_OUT` keeps prior value.
- **Timeout:** `TIMEOUT=4`, load with `mem_ready` held low -> `mem_req` high exactly 4 cycles; then DONE with `MemErr=1` and `ReadData_OUT=0`.
- **Reset mid-REQ:** `RST_N` low during cycle 2 of a pending load -> `mem_req`, `Stall` and `ReadData_OUT` go to 0 without waiting for a clock edge; after release, a new load completes normally.
- **Back-to-back:** load then store in consecutive instructions -> two separate handshakes; `Stall` low for exactly one DONE cycle between them; no duplicate `mem_req`.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory access controller.
// Runs a req/ready handshake and stalls the pipeline while waiting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData_OUT,
  output logic        Stall,
  output logic        MemErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       access;
  logic       bad;

  assign access = MemRead | MemWrite;
  assign bad    = (ALUResult[1:0] != 2'b00)
                | (MemRead & MemWrite);

  // Bus request and stall are decoded from the state register so both
  // drop immediately when reset clears the state.
  assign mem_req = (state == REQ);
  assign Stall   = (state == REQ)
                 | ((state == IDLE) & access);

  // Handshake FSM with latched bus fields, wait counter and load data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      ReadData_OUT <= 32'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_we       <= 1'b0;
      MemErr       <= 1'b0;
    end else begin
      MemErr <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (bad) begin
              MemErr <= 1'b1;
              state  <= DONE;
            end else begin
              mem_addr  <= ALUResult;
              mem_wdata <= WriteData;
              mem_we    <= MemWrite;
              cnt       <= 8'd0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (!mem_we) ReadData_OUT <= mem_rdata;
            state <= DONE;
          end else if (cnt == LAST) begin
            if (!mem_we) ReadData_OUT <= 32'd0;
            MemErr <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests for mem_access_unit.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_mem_access_unit;

  logic        CLK;
  logic        RST_N;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData_OUT;
  logic        Stall;
  logic        MemErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .ReadData_OUT(ReadData_OUT),
    .Stall       (Stall),
    .MemErr      (MemErr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST_N = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    #1;
    checks++;
    if ({Stall, mem_req, MemErr, mem_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 0000",
               {Stall, mem_req, MemErr, mem_we});
    end
    checks++;
    if ({ReadData_OUT, mem_addr, mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: rd=%h a=%h wd=%h exp 0",
               ReadData_OUT, mem_addr, mem_wdata);
    end
    MemRead = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_stall: got %b exp 1", Stall);
    end
    MemRead = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_stall: got %b exp 0", Stall);
    end
  endtask

  task automatic test_no_access();
    @(negedge CLK);
    ALUResult = 32'h3;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({Stall, mem_req, MemErr} !== 3'b000) begin
        errors++;
        $display("FAIL no_access c%0d: got %b exp 000",
                 i, {Stall, mem_req, MemErr});
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_load_ready();
    MemRead = 1'b1;
    ALUResult = 32'h100;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({Stall, mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL load_c0: got %b exp 10", {Stall, mem_req});
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Stall, mem_req, mem_we} !== 3'b110 ||
        mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL load_c1: ctrl=%b a=%h exp 110 100",
               {Stall, mem_req, mem_we}, mem_addr);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Stall, mem_req, MemErr} !== 3'b000 ||
        ReadData_OUT !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_done: ctrl=%b rd=%h exp 000 deadbeef",
               {Stall, mem_req, MemErr}, ReadData_OUT);
    end
  endtask

  task automatic test_store_wait();
    int nstall;
    @(negedge CLK);
    MemRead = 1'b0;
    MemWrite = 1'b1;
    ALUResult = 32'h24;
    WriteData = 32'h12345678;
    mem_ready = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    #1;
    nstall = Stall ? 1 : 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      mem_ready = (i == 4);
      #1;
      if (Stall) nstall++;
      checks++;
      if ({mem_req, mem_we} !== 2'b11 ||
          mem_wdata !== 32'h12345678 ||
          mem_addr !== 32'h24) begin
        errors++;
        $display("FAIL store_req c%0d: rq/we=%b wd=%h a=%h",
                 i, {mem_req, mem_we}, mem_wdata, mem_addr);
      end
    end
    @(negedge CLK);
    #1;
    checks++;
    if (nstall !== 5 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL store_stalls: got %0d stall=%b exp 5 0",
               nstall, Stall);
    end
    checks++;
    if (ReadData_OUT !== 32'hDEADBEEF || MemErr !== 1'b0) begin
      errors++;
      $display("FAIL store_rd: rd=%h err=%b exp deadbeef 0",
               ReadData_OUT, MemErr);
    end
  endtask

  task automatic test_error(input logic rd, input logic wr,
                            input logic [31:0] addr);
    @(negedge CLK);
    MemRead = rd;
    MemWrite = wr;
    ALUResult = addr;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({Stall, mem_req, MemErr} !== 3'b100) begin
      errors++;
      $display("FAIL err_c0 %h: got %b exp 100",
               addr, {Stall, mem_req, MemErr});
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({Stall, mem_req, MemErr} !== 3'b001 ||
        ReadData_OUT !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL err_done %h: ctrl=%b rd=%h exp 001 deadbeef",
               addr, {Stall, mem_req, MemErr}, ReadData_OUT);
    end
    @(negedge CLK);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    #1;
    checks++;
    if ({Stall, mem_req, MemErr} !== 3'b000) begin
      errors++;
      $display("FAIL err_after %h: got %b exp 000",
               addr, {Stall, mem_req, MemErr});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] st;
    logic [5:0] rq;
    st = '0;
    rq = '0;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    WriteData = 32'h11223344;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      MemRead = (i < 3);
      MemWrite = (i >= 3);
      ALUResult = (i < 3) ? 32'h300 : 32'h304;
      #1;
      st[i] = Stall;
      rq[i] = mem_req;
      if (i == 4) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h304 ||
            mem_wdata !== 32'h11223344) begin
          errors++;
          $display("FAIL b2b_store: we=%b a=%h wd=%h",
                   mem_we, mem_addr, mem_wdata);
        end
      end
    end
    checks++;
    if (st !== 6'b011011) begin
      errors++;
      $display("FAIL b2b_stall: got %b exp 011011", st);
    end
    checks++;
    if (rq !== 6'b010010) begin
      errors++;
      $display("FAIL b2b_req: got %b exp 010010", rq);
    end
    checks++;
    if (ReadData_OUT !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_rd: got %h exp a5a5a5a5", ReadData_OUT);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    MemRead = 1'b1;
    MemWrite = 1'b0;
    ALUResult = 32'h400;
    mem_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: req=%b exp 1", mem_req);
    end
    #1;
    RST_N = 1'b0;
    MemRead = 1'b0;
    #1;
    checks++;
    if ({mem_req, Stall} !== 2'b00 || ReadData_OUT !== 32'd0 ||
        mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_async: rq/st=%b rd=%h a=%h exp 00 0 0",
               {mem_req, Stall}, ReadData_OUT, mem_addr);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    MemRead = 1'b1;
    ALUResult = 32'h404;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    #1;
    checks++;
    if ({Stall, mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_c0: got %b exp 10", {Stall, mem_req});
    end
    @(negedge CLK);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h404) begin
      errors++;
      $display("FAIL rstmid_c1: req=%b a=%h exp 1 404",
               mem_req, mem_addr);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData_OUT !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL rstmid_done: st=%b rd=%h exp 0 0badf00d",
               Stall, ReadData_OUT);
    end
  endtask

  task automatic test_timeout();
    int nreq;
    int nstall;
    @(negedge CLK);
    MemRead = 1'b1;
    ALUResult = 32'h200;
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    nreq = 0;
    nstall = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!Stall) break;
      nstall++;
      if (mem_req) nreq++;
      @(negedge CLK);
      #1;
    end
    checks++;
    if (nreq !== 4 || nstall !== 5) begin
      errors++;
      $display("FAIL timeout_len: req=%0d stall=%0d exp 4 5",
               nreq, nstall);
    end
    checks++;
    if (MemErr !== 1'b1 || ReadData_OUT !== 32'd0) begin
      errors++;
      $display("FAIL timeout_done: err=%b rd=%h exp 1 0",
               MemErr, ReadData_OUT);
    end
    @(negedge CLK);
    MemRead = 1'b0;
    #1;
    checks++;
    if ({MemErr, Stall, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_after: got %b exp 000",
               {MemErr, Stall, mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_no_access();
    test_load_ready();
    test_store_wait();
    test_error(1'b1, 1'b0, 32'h102);
    test_error(1'b1, 1'b1, 32'h40);
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
